ws2812b_stream_driver: RTL
==========================

# ws2812b_stream_driver

Parametrised WS2812B strip driver with an internal run-length pixel FIFO and on-chip bit timing. It is the successor to the byte-peripheral LED path: the bus-side logic pushes `{latch, count, GRB}` entries and the block serialises them back to back with no inter-pixel gaps. It generates the strip reset/latch interval itself and flags FIFO underruns. It sits between a TinyQV peripheral register file and a single output pin.

## Interface
- `CLK_MHZ`, 64: clock frequency in MHz, integer.
- `T0H_NS`, 400: high time of a 0 bit.
- `T1H_NS`, 800: high time of a 1 bit.
- `BIT_NS`, 1250: full bit period.
- `RESET_US`, 300: low time that latches the strip.
- `DEPTH`, 8: FIFO entries, power of two, ≥ 2.
- `CNT_W`, 6: width of the per-entry repeat field.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `push_valid`  in  1  entry offered.
- `push_ready`  out  1  FIFO can accept an entry; equals `!full`.
- `push_color`  in  24  pixel colour `{G,R,B}`; bit 23 is sent first.
- `push_count`  in  CNT_W  repeat field; pixels sent = `push_count + 1`.
- `push_latch`  in  1  after this entry's last pixel, hold the line low for the reset interval.
- `fifo_level`  out  $clog2(DEPTH)+1  number of stored entries.
- `busy`  out  1  serialiser not in IDLE.
- `underrun`  out  1  one-cycle pulse, see Operation.
- `led`  out  1  registered strip data output.

## Operation
- Derived cycle counts, truncating integer maths:
  - `T0_CYC = CLK_MHZ*T0H_NS/1000` (25 at defaults)
  - `T1_CYC = CLK_MHZ*T1H_NS/1000` (51)
  - `BIT_CYC = CLK_MHZ*BIT_NS/1000` (80)
  - `RST_CYC = CLK_MHZ*RESET_US` (19200)
- Counters are sized with `$clog2`.
- FIFO:
  - Synchronous, entry width `25+CNT_W`.
  - A write occurs on `push_valid & push_ready`.
  - `push_ready` depends only on `full`; a same-cycle pop does not free a slot for that cycle's push.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
- States: IDLE, SEND, LATCH.
  - IDLE, FIFO non-empty: pop the head; load colour, repeat counter = count, bit index 23, cycle counter 0; go to SEND.
  - SEND: the bit period runs for cycles 0..BIT_CYC-1. `led`=1 during cycles 0..(bit?T1_CYC:T0_CYC)-1, 0 otherwise.
  - SEND, end of bit: at the last cycle of a bit, decrement the bit index. At the end of bit 0, reload bit index 23 and decrement the repeat counter.
  - SEND, end of entry: at the last cycle of bit 0 with repeat counter 0:
    - latch=1: go to LATCH.
    - Else, FIFO non-empty: pop and continue SEND with the new entry. The next bit starts on the very next cycle (gapless).
    - Else: go to IDLE and pulse `underrun` for one cycle.
  - LATCH: `led`=0 for exactly RST_CYC cycles, then go to IDLE. Entries may be pushed during LATCH and are not popped until IDLE.
- `busy` = state != IDLE.
- The count field is never treated as zero pixels; `push_count`=0 sends 1 pixel.

## Timing
- Reset values: `led`=0, `busy`=0, `underrun`=0, `fifo_level`=0, `push_ready`=1. State is IDLE and all counters are 0.
- Reset asserted mid-operation: FIFO is emptied and `led` drops low asynchronously. The partial pixel is abandoned with no latch interval.
- Latency from an idle, empty FIFO:
  - Push accepted on edge k: `fifo_level`=1 after edge k.
  - Pop and `busy`=1 after edge k+1.
  - `led` rises after edge k+2.
- Entry duration:
  - Without latch: `(count+1)*24*BIT_CYC` cycles.
  - With latch: add RST_CYC.
- Back-to-back entries: no idle cycle between the last bit of one entry and the first bit of the next while the FIFO is non-empty.
- `underrun` is asserted in the cycle the state becomes IDLE from SEND. It is never asserted after a latch entry.

## Test plan
- Single-pixel frame:
  - Stimulus: push color 0xFF0000, count 0, latch 1.
  - Required: 8 bits with 51 high / 29 low cycles, then 16 bits with 25 high / 55 low; `led` low for 19200 cycles; `busy` falls 1920+19200 cycles after the first rise; `underrun` never asserted.
- Run-length:
  - Stimulus: push color 0x0000AA, count 2, latch 1.
  - Required: the 24-bit pattern repeats exactly 3 times (5760 cycles), followed by the latch interval.
- Gapless chaining:
  - Stimulus: push A (0x123456, count 0, latch 0) and B (0xABCDEF, count 0, latch 1) before A completes.
  - Required: B's first rising edge lands exactly 1920 cycles after A's first rising edge; no `underrun`.
- Full/backpressure:
  - Stimulus: hold `push_valid` for 10 cycles while the block is in LATCH.
  - Required: exactly 8 entries accepted; `push_ready`=0 at level 8; the first pop drops `fifo_level` to 7.
- Underrun:
  - Stimulus: push one entry with latch 0.
  - Required: one-cycle `underrun` pulse as `busy` falls; `led` stays 0 afterwards.
- Async reset mid-bit:
  - Stimulus: assert `reset` 10 cycles into a 1 bit (`led`=1).
  - Required: `led`=0, `fifo_level`=0, `busy`=0 before the next clock edge. After release, a new push produces a correct frame.

Source files
------------

// File: rtl/ws2812b_stream_driver.sv
// ============================================================================
// Module      : ws2812b_stream_driver
// Description : WS2812B strip driver. Run-length pixel FIFO of {latch, count,
//               GRB} entries, gapless bit serialiser, built-in latch interval
//               and underrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ws2812b_stream_driver #(
  parameter int CLK_MHZ  = 64,
  parameter int T0H_NS   = 400,
  parameter int T1H_NS   = 800,
  parameter int BIT_NS   = 1250,
  parameter int RESET_US = 300,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 6
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [23:0]              push_color_i,
  input  logic [CNT_W-1:0]         push_count_i,
  input  logic                     push_latch_i,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     busy_o,
  output logic                     underrun_o,
  output logic                     led_o
);

  localparam int T0_CYC  = CLK_MHZ * T0H_NS / 1000;
  localparam int T1_CYC  = CLK_MHZ * T1H_NS / 1000;
  localparam int BIT_CYC = CLK_MHZ * BIT_NS / 1000;
  localparam int RST_CYC = CLK_MHZ * RESET_US;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BIT_CYC);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int EW = 25 + CNT_W;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC - 1);
  localparam logic [BW-1:0] T0_VAL   = BW'(T0_CYC);
  localparam logic [BW-1:0] T1_VAL   = BW'(T1_CYC);
  // The pin is one register stage behind the state; holding LATCH one extra
  // state cycle makes the pin-side low time after the final bit period equal
  // RST_CYC at the moment busy drops.
  localparam logic [RW-1:0] LAT_LAST = RW'(RST_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  // FIFO storage and pointers
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;

  // Serialiser state
  state_t           state_q;
  logic [23:0]      color_q;
  logic [CNT_W-1:0] rep_q;
  logic             latch_q;
  logic [4:0]       bit_q;
  logic [BW-1:0]    cyc_q;
  logic [RW-1:0]    lat_q;
  logic             led_q;
  logic             underrun_q;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             bit_end;
  logic             entry_end;
  logic [EW-1:0]    head;
  logic [23:0]      head_color;
  logic [CNT_W-1:0] head_count;
  logic             head_latch;
  logic [BW-1:0]    high_cyc;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);
  assign push       = push_valid_i & ~fifo_full;

  assign head       = mem_q[rd_ptr_q];
  assign head_color = head[23:0];
  assign head_count = head[24 +: CNT_W];
  assign head_latch = head[EW-1];

  assign bit_end    = (cyc_q == BIT_LAST);
  assign entry_end  = (state_q == S_SEND) && bit_end && (bit_q == 5'd0) && (rep_q == '0);
  // Pop when idle, or at the last cycle of a non-latching entry so the next
  // entry's first bit starts on the very next cycle.
  assign pop        = ~fifo_empty && ((state_q == S_IDLE) || (entry_end && ~latch_q));

  assign high_cyc   = color_q[bit_q] ? T1_VAL : T0_VAL;

  assign push_ready_o = ~fifo_full;
  assign fifo_level_o = level_q;
  assign busy_o       = (state_q != S_IDLE);
  assign underrun_o   = underrun_q;
  assign led_o        = led_q;

  // FIFO entry storage; contents need no reset since level gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_latch_i, push_count_i, push_color_i};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the level alone
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Serialiser FSM with registered pin and underrun outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      color_q    <= '0;
      rep_q      <= '0;
      latch_q    <= 1'b0;
      bit_q      <= '0;
      cyc_q      <= '0;
      lat_q      <= '0;
      led_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      led_q      <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            color_q <= head_color;
            rep_q   <= head_count;
            latch_q <= head_latch;
            bit_q   <= 5'd23;
            cyc_q   <= '0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          led_q <= (cyc_q < high_cyc);
          if (!bit_end) begin
            cyc_q <= cyc_q + 1'b1;
          end else begin
            cyc_q <= '0;
            if (bit_q != 5'd0) begin
              bit_q <= bit_q - 5'd1;
            end else begin
              bit_q <= 5'd23;
              if (rep_q != '0) begin
                rep_q <= rep_q - 1'b1;
              end else if (latch_q) begin
                lat_q   <= '0;
                state_q <= S_LATCH;
              end else if (!fifo_empty) begin
                color_q <= head_color;
                rep_q   <= head_count;
                latch_q <= head_latch;
              end else begin
                underrun_q <= 1'b1;
                state_q    <= S_IDLE;
              end
            end
          end
        end
        S_LATCH: begin
          if (lat_q == LAT_LAST) begin
            lat_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
